// File: rtl/apb_regbank_pkg.sv
// rtl/apb_regbank_pkg.sv - shared FSM encoding, register offsets and bit indices for the APB register bank
package apb_regbank_pkg;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_SETUP  = 2'b01;
   localparam logic [1:0] ST_ACCESS = 2'b10;

   localparam logic [7:0] OFF_CTRL     = 8'h00;
   localparam logic [7:0] OFF_STATUS   = 8'h04;
   localparam logic [7:0] OFF_COUNT    = 8'h08;
   localparam logic [7:0] OFF_COMPARE  = 8'h0C;
   localparam logic [7:0] OFF_SCRATCH0 = 8'h10;

   localparam int CTRL_CNT_EN = 0;
   localparam int CTRL_IRQ_EN = 1;

   localparam int STAT_MATCH = 0;
   localparam int STAT_WRAP  = 1;
   localparam int STAT_PERR  = 2;

   // Byte offset to the word index decoded from Paddr[7:2]
   function automatic logic [5:0] word_of(input logic [7:0] off);
      return 6'(off >> 2);
   endfunction

endpackage

// File: rtl/apb_match_counter.sv
// rtl/apb_match_counter.sv - free-running counter with compare-match reset, wrap detect and APB load
module apb_match_counter
   import apb_regbank_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_val,
   input  logic                 cmp_wr,
   input  logic [CNT_WIDTH-1:0] cmp_val,
   output logic [CNT_WIDTH-1:0] count,
   output logic [CNT_WIDTH-1:0] compare,
   output logic                 match,
   output logic                 wrap
);

   logic hit;
   logic at_max;

   assign hit    = en && (count == compare);
   assign at_max = (count == {CNT_WIDTH{1'b1}});

   // A load overrides the match-reset, so no event is reported in that cycle
   assign match = hit && !load;
   assign wrap  = en && at_max && !hit && !load;

   // Count, match-reset, wrap and load; a load always wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         compare <= '0;
      end else begin
         if (cmp_wr) begin
            compare <= cmp_val;
         end
         if (load) begin
            count <= load_val;
         end else if (match || wrap) begin
            count <= '0;
         end else if (en) begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - APB slave with phase tracking, protocol checks and control/status/counter/scratch registers
module apb_slave_regbank
   import apb_regbank_pkg::*;
#(
   parameter int NUM_SCRATCH = 8,
   parameter int CNT_WIDTH   = 32
) (
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic        Psel,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        irq
);

   localparam logic [5:0] W_CTRL    = word_of(OFF_CTRL);
   localparam logic [5:0] W_STATUS  = word_of(OFF_STATUS);
   localparam logic [5:0] W_COUNT   = word_of(OFF_COUNT);
   localparam logic [5:0] W_COMPARE = word_of(OFF_COMPARE);
   localparam logic [5:0] W_SCR0    = word_of(OFF_SCRATCH0);

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic [5:0]           addr_q;
   logic                 write_q;
   logic [1:0]           ctrl;
   logic [2:0]           status;
   logic [2:0]           st_set;
   logic [2:0]           st_clr;
   logic [31:0]          scratch [NUM_SCRATCH];
   logic [31:0]          rd_val;
   logic [CNT_WIDTH-1:0] count;
   logic [CNT_WIDTH-1:0] compare;
   logic                 cnt_match;
   logic                 cnt_wrap;
   logic                 setup_cyc;
   logic                 enable_cyc;
   logic                 perr;
   logic                 wr_en;
   logic [5:0]           paddr_word;
   logic                 unused_paddr;

   assign paddr_word   = Paddr[7:2];
   assign unused_paddr = ^{Paddr[31:8], Paddr[1:0]};
   assign setup_cyc    = Psel & ~Penable;
   assign enable_cyc   = Psel & Penable;

   // An enable phase is only legal straight after SETUP and must repeat the latched address and direction
   always_comb begin
      perr = 1'b0;
      if (enable_cyc) begin
         case (state)
            ST_SETUP: perr = (paddr_word != addr_q) || (Pwrite != write_q);
            default:  perr = 1'b1;
         endcase
      end
   end

   assign wr_en = enable_cyc && (state == ST_SETUP) && write_q && !perr;

   // Phase tracking; SETUP with another setup cycle simply restarts the setup
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (setup_cyc) state_nxt = ST_SETUP;
         end
         ST_SETUP: begin
            if (!Psel)        state_nxt = ST_IDLE;
            else if (Penable) state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (!Psel)         state_nxt = ST_IDLE;
            else if (!Penable) state_nxt = ST_SETUP;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Read mux on the live setup address
   always_comb begin
      rd_val = '0;
      case (paddr_word)
         W_CTRL:    rd_val = {30'b0, ctrl};
         W_STATUS:  rd_val = {29'b0, status};
         W_COUNT:   rd_val = 32'(count);
         W_COMPARE: rd_val = 32'(compare);
         default: begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
               if (paddr_word == W_SCR0 + 6'(i)) rd_val = scratch[i];
            end
         end
      endcase
   end

   // Hardware-set STATUS events and W1C clear mask
   always_comb begin
      st_set             = '0;
      st_set[STAT_MATCH] = cnt_match;
      st_set[STAT_WRAP]  = cnt_wrap;
      st_set[STAT_PERR]  = perr;
      st_clr             = (wr_en && addr_q == W_STATUS) ? Pwdata[2:0] : 3'b0;
   end

   // FSM, setup latch and registered read data loaded at the end of a read setup
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         Prdata  <= '0;
      end else begin
         state <= state_nxt;
         if (setup_cyc) begin
            addr_q  <= paddr_word;
            write_q <= Pwrite;
            if (!Pwrite) Prdata <= rd_val;
         end
      end
   end

   // CTRL, STATUS, scratch writes and the registered interrupt
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         ctrl   <= '0;
         status <= '0;
         irq    <= 1'b0;
         for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
      end else begin
         irq    <= ctrl[CTRL_IRQ_EN] & status[STAT_MATCH];
         status <= (status & ~st_clr) | st_set;
         if (wr_en && addr_q == W_CTRL) ctrl <= Pwdata[1:0];
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (wr_en && addr_q == W_SCR0 + 6'(i)) scratch[i] <= Pwdata;
         end
      end
   end

   apb_match_counter #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_counter (
      .clk      (Hclk),
      .rst_n    (Hresetn),
      .en       (ctrl[CTRL_CNT_EN]),
      .load     (wr_en && addr_q == W_COUNT),
      .load_val (Pwdata[CNT_WIDTH-1:0]),
      .cmp_wr   (wr_en && addr_q == W_COMPARE),
      .cmp_val  (Pwdata[CNT_WIDTH-1:0]),
      .count    (count),
      .compare  (compare),
      .match    (cnt_match),
      .wrap     (cnt_wrap)
   );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb/tb_apb_slave_regbank.sv - self-checking bench for apb_slave_regbank against a transaction-level model
module tb_apb_slave_regbank;

   localparam int NS = 8;

   logic        Hclk;
   logic        Hresetn;
   logic        Psel;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   logic [1:0]  m_ctrl;
   logic [2:0]  m_status;
   logic [31:0] m_count;
   logic [31:0] m_compare;
   logic [31:0] m_prdata;
   logic        m_irq;
   logic [31:0] m_scr [NS];

   // what the driver says the current cycle means
   logic        i_wr;
   logic [5:0]  i_wr_word;
   logic [31:0] i_wr_data;
   logic        i_rd;
   logic [5:0]  i_rd_word;
   logic        i_perr;
   logic        chk_rd;

   apb_slave_regbank #(
      .NUM_SCRATCH(NS),
      .CNT_WIDTH  (32)
   ) dut (
      .Hclk    (Hclk),
      .Hresetn (Hresetn),
      .Psel    (Psel),
      .Penable (Penable),
      .Pwrite  (Pwrite),
      .Paddr   (Paddr),
      .Pwdata  (Pwdata),
      .Prdata  (Prdata),
      .irq     (irq)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [5:0] w);
      if (w == 6'd0) return {30'b0, m_ctrl};
      if (w == 6'd1) return {29'b0, m_status};
      if (w == 6'd2) return m_count;
      if (w == 6'd3) return m_compare;
      if (w >= 6'd4 && int'(w) < 4 + NS) return m_scr[int'(w) - 4];
      return 32'h0;
   endfunction

   // Register-level model advanced once per clock from the driver's declared intent
   always @(posedge Hclk or negedge Hresetn) begin : model_step
      logic [32:0] inc;
      logic [2:0]  set_b;
      logic [2:0]  clr_b;
      logic        hit;
      if (!Hresetn) begin
         m_ctrl    = '0;
         m_status  = '0;
         m_count   = '0;
         m_compare = '0;
         m_prdata  = '0;
         m_irq     = 1'b0;
         for (int i = 0; i < NS; i++) m_scr[i] = '0;
      end else begin
         if (i_rd) m_prdata = model_read(i_rd_word);
         m_irq = m_ctrl[1] & m_status[0];
         set_b = {i_perr, 2'b00};
         clr_b = 3'b000;
         hit   = m_ctrl[0] && (m_count == m_compare);
         if (i_wr && i_wr_word == 6'd2) begin
            m_count = i_wr_data;
         end else if (hit) begin
            m_count  = 32'h0;
            set_b[0] = 1'b1;
         end else if (m_ctrl[0]) begin
            inc = {1'b0, m_count} + 33'd1;
            if (inc[32]) set_b[1] = 1'b1;
            m_count = inc[31:0];
         end
         if (i_wr) begin
            if (i_wr_word == 6'd0) m_ctrl = i_wr_data[1:0];
            if (i_wr_word == 6'd1) clr_b = i_wr_data[2:0];
            if (i_wr_word == 6'd3) m_compare = i_wr_data;
            if (i_wr_word >= 6'd4 && int'(i_wr_word) < 4 + NS) m_scr[int'(i_wr_word) - 4] = i_wr_data;
         end
         m_status = (m_status & ~clr_b) | set_b;
      end
   end

   // Compare process: irq every cycle, Prdata during every read enable phase
   always @(negedge Hclk) begin
      if (Hresetn) begin
         check("irq", {31'b0, irq}, {31'b0, m_irq});
         if (chk_rd) check("prdata", Prdata, m_prdata);
      end
   end

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic idle(input int n);
      Psel    = 1'b0;
      Penable = 1'b0;
      repeat (n) tick();
   endtask

   task automatic apb_write(input logic [5:0] w, input logic [31:0] d);
      logic [31:0] a;
      a = $urandom;
      a[7:2] = w;
      Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = a; Pwdata = d;
      tick();
      Penable = 1'b1; i_wr = 1'b1; i_wr_word = w; i_wr_data = d;
      tick();
      i_wr = 1'b0; Psel = 1'b0; Penable = 1'b0;
   endtask

   task automatic apb_read(input logic [5:0] w, output logic [31:0] d);
      logic [31:0] a;
      a = $urandom;
      a[7:2] = w;
      Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = a;
      i_rd = 1'b1; i_rd_word = w;
      tick();
      i_rd = 1'b0; Penable = 1'b1; chk_rd = 1'b1;
      @(negedge Hclk);
      d = Prdata;
      tick();
      chk_rd = 1'b0; Psel = 1'b0; Penable = 1'b0;
   endtask

   task automatic apb_write_bad(input logic [5:0] w, input logic [31:0] d, input bit flip_dir);
      logic [31:0] a;
      a = $urandom;
      a[7:2] = w;
      Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = a; Pwdata = d;
      tick();
      Penable = 1'b1; i_perr = 1'b1;
      if (flip_dir) Pwrite = 1'b0;
      else          Paddr[7:2] = w ^ 6'h1;
      tick();
      i_perr = 1'b0; Psel = 1'b0; Penable = 1'b0;
   endtask

   task automatic apb_bad_enable();
      Psel = 1'b1; Penable = 1'b1; Pwrite = 1'($urandom_range(0, 1)); i_perr = 1'b1;
      tick();
      i_perr = 1'b0; Psel = 1'b0; Penable = 1'b0;
   endtask

   task automatic apb_abort(input logic [5:0] w, input bit is_wr);
      logic [31:0] a;
      a = $urandom;
      a[7:2] = w;
      Psel = 1'b1; Penable = 1'b0; Pwrite = is_wr; Paddr = a; Pwdata = $urandom;
      i_rd = !is_wr; i_rd_word = w;
      tick();
      i_rd = 1'b0; Psel = 1'b0;
      tick();
   endtask

   function automatic logic [5:0] rand_word();
      if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
      return 6'($urandom_range(0, 13));
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] d;
      int          k;
      int          r;
      logic [5:0]  w;
      logic [31:0] v;

      Hresetn = 1'b0; Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
      Paddr = '0; Pwdata = '0;
      i_wr = 1'b0; i_wr_word = '0; i_wr_data = '0;
      i_rd = 1'b0; i_rd_word = '0; i_perr = 1'b0; chk_rd = 1'b0;
      repeat (3) tick();
      Hresetn = 1'b1;

      // reset values
      check("rst_irq", {31'b0, irq}, 32'h0);
      apb_read(6'd0, d); check("rst_ctrl", d, 32'h0);
      apb_read(6'd1, d); check("rst_status", d, 32'h0);
      apb_read(6'd2, d); check("rst_count", d, 32'h0);
      apb_read(6'd3, d); check("rst_compare", d, 32'h0);
      apb_read(6'd4, d); check("rst_scratch0", d, 32'h0);

      // write then back-to-back read, unmapped read
      apb_write(6'd5, 32'hDEADBEEF);
      apb_read(6'd5, d);  check("scratch1_rd", d, 32'hDEADBEEF);
      apb_read(6'd16, d); check("unmapped_rd", d, 32'h0);

      // compare match and irq timing
      apb_write(6'd3, 32'd5);
      apb_write(6'd0, 32'h3);
      k = 0;
      while (irq == 1'b0 && k < 50) begin
         tick();
         k++;
      end
      check("irq_latency", 32'(k), 32'd7);
      apb_write(6'd0, 32'h2);
      apb_read(6'd2, d); check("count_restart", d, 32'd3);
      apb_read(6'd1, d); check("status_match", d, 32'h1);
      apb_write(6'd1, 32'h1);
      check("irq_before_drop", {31'b0, irq}, 32'h1);
      tick();
      check("irq_dropped", {31'b0, irq}, 32'h0);

      // wrap past all-ones without a match
      apb_write(6'd3, 32'd3);
      apb_write(6'd2, 32'hFFFFFFFE);
      apb_write(6'd0, 32'h1);
      idle(2);
      apb_read(6'd1, d); check("status_wrap", d, 32'h2);
      apb_read(6'd2, d);
      apb_write(6'd0, 32'h0);
      apb_write(6'd1, 32'h7);

      // protocol errors
      idle(1);
      apb_bad_enable();
      apb_read(6'd1, d); check("perr_no_setup", d, 32'h4);
      apb_write(6'd1, 32'h7);
      apb_write_bad(6'd4, 32'h12345678, 1'b0);
      apb_read(6'd1, d); check("perr_addr_change", d, 32'h4);
      apb_read(6'd4, d); check("scratch0_untouched", d, 32'h0);

      // reset during the enable phase of a write
      apb_read(6'd5, d); check("prdata_pre_reset", d, 32'hDEADBEEF);
      Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'hA5A5A5A5;
      tick();
      Penable = 1'b1; i_wr = 1'b1; i_wr_word = 6'd4; i_wr_data = 32'hA5A5A5A5;
      #2;
      Hresetn = 1'b0;
      i_wr = 1'b0;
      #1;
      check("async_prdata", Prdata, 32'h0);
      check("async_irq", {31'b0, irq}, 32'h0);
      Psel = 1'b0; Penable = 1'b0;
      tick();
      tick();
      Hresetn = 1'b1;
      apb_read(6'd4, d); check("scratch0_lost_write", d, 32'h0);
      apb_read(6'd5, d); check("scratch1_cleared", d, 32'h0);

      // randomized traffic checked by the compare process
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         w = rand_word();
         v = $urandom;
         if (r < 35) begin
            if (w == 6'd2) v = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20))
                                                          : 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            if (w == 6'd3) v = 32'($urandom_range(0, 20));
            apb_write(w, v);
         end else if (r < 70) begin
            apb_read(w, d);
         end else if (r < 78) begin
            idle($urandom_range(1, 3));
         end else if (r < 84) begin
            apb_abort(w, 1'($urandom_range(0, 1)));
         end else if (r < 89) begin
            apb_bad_enable();
         end else if (r < 94) begin
            apb_write_bad(w, v, 1'($urandom_range(0, 1)));
         end else begin
            apb_write(6'd0, 32'($urandom_range(0, 3)));
         end
      end

      // final sweep of the whole map
      for (int i = 0; i < 4 + NS + 2; i++) apb_read(6'(i), d);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
